// File: rtl/mem_loader_if.sv
// Byte-stream handshake into the loader: IN_DATA moves when IN_VALID and IN_READY are both high at a clock edge.
// The master is the stream source, and the slave is the loader.
interface mem_loader_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] IN_DATA;
    logic                  IN_VALID;
    logic                  IN_READY;

    modport master (
        output IN_DATA,
        output IN_VALID,
        input  IN_READY
    );

    modport slave (
        input  IN_DATA,
        input  IN_VALID,
        output IN_READY
    );
endinterface

// File: rtl/mem_loader.sv
// Streams LEN bytes into an async SRAM starting at BASE_ADDR, then reads the same bytes back and compares sums.
// Latency: each byte takes 2 cycles to write and 2 cycles to read back; DONE comes 4*LEN+1 cycles after START.
// Backpressure: IN_READY is high only in LOAD, so a stalled source just holds the FSM in LOAD.
module mem_loader #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  START,
    input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
    input  logic [ADDR_WIDTH-1:0] LEN,
    mem_loader_if.slave           in_s,
    output logic [ADDR_WIDTH-1:0] MEM_A,
    inout  wire  [DATA_WIDTH-1:0] MEM_DIO,
    output logic                  MEM_CS_N,
    output logic                  MEM_OE_N,
    output logic                  MEM_WR_N,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERROR,
    output logic [DATA_WIDTH-1:0] CHECKSUM
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        WRITE   = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        FINISH  = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [ADDR_WIDTH-1:0] len_r;
    logic [ADDR_WIDTH-1:0] remaining;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] vsum;
    logic [DATA_WIDTH-1:0] rd_sum;

    // The data bus is driven from the registered write strobe, so it cannot float low between cycles.
    assign MEM_DIO = MEM_WR_N ? {DATA_WIDTH{1'bz}} : wdata;
    assign rd_sum  = vsum + MEM_DIO;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= IDLE;
            base_r        <= '0;
            len_r         <= '0;
            remaining     <= '0;
            wdata         <= '0;
            vsum          <= '0;
            MEM_A         <= '0;
            MEM_CS_N      <= 1'b1;
            MEM_OE_N      <= 1'b1;
            MEM_WR_N      <= 1'b1;
            in_s.IN_READY <= 1'b0;
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
            ERROR         <= 1'b0;
            CHECKSUM      <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        base_r    <= BASE_ADDR;
                        MEM_A     <= BASE_ADDR;
                        len_r     <= LEN;
                        remaining <= LEN;
                        CHECKSUM  <= '0;
                        vsum      <= '0;
                        ERROR     <= 1'b0;
                        BUSY      <= 1'b1;
                        if (LEN != '0) begin
                            in_s.IN_READY <= 1'b1;
                            state         <= LOAD;
                        end else begin
                            DONE  <= 1'b1;
                            state <= FINISH;
                        end
                    end
                end

                LOAD: begin
                    if (in_s.IN_VALID && in_s.IN_READY) begin
                        wdata         <= in_s.IN_DATA;
                        CHECKSUM      <= CHECKSUM + in_s.IN_DATA;
                        in_s.IN_READY <= 1'b0;
                        MEM_CS_N      <= 1'b0;
                        MEM_WR_N      <= 1'b0;
                        state         <= WRITE;
                    end
                end

                // The write strobe rises on the same edge that the read strobe falls, so the two never overlap.
                WRITE: begin
                    MEM_WR_N <= 1'b1;
                    if (remaining != ADDR_ONE) begin
                        remaining     <= remaining - ADDR_ONE;
                        MEM_A         <= MEM_A + ADDR_ONE;
                        MEM_CS_N      <= 1'b1;
                        in_s.IN_READY <= 1'b1;
                        state         <= LOAD;
                    end else begin
                        remaining <= len_r;
                        MEM_A     <= base_r;
                        MEM_OE_N  <= 1'b0;
                        state     <= RD_ADDR;
                    end
                end

                RD_ADDR: begin
                    state <= RD_DATA;
                end

                RD_DATA: begin
                    vsum      <= rd_sum;
                    MEM_A     <= MEM_A + ADDR_ONE;
                    remaining <= remaining - ADDR_ONE;
                    if (remaining != ADDR_ONE) begin
                        state <= RD_ADDR;
                    end else begin
                        MEM_CS_N <= 1'b1;
                        MEM_OE_N <= 1'b1;
                        DONE     <= 1'b1;
                        ERROR    <= (rd_sum != CHECKSUM);
                        state    <= FINISH;
                    end
                end

                FINISH: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    MEM_CS_N      <= 1'b1;
                    MEM_OE_N      <= 1'b1;
                    MEM_WR_N      <= 1'b1;
                    in_s.IN_READY <= 1'b0;
                    BUSY          <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 15, SHALL set the memory address width.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the data and checksum width.
REQ-003 CLK  in  1  SHALL be the single clock; all state updates on posedge.
REQ-004 RESET_N  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 START  in  1  SHALL request a load; sampled only in IDLE.
REQ-006 BASE_ADDR  in  ADDR_WIDTH  SHALL be the first target address, captured on accepted START.
REQ-007 LEN  in  ADDR_WIDTH  SHALL be the byte count, captured on accepted START; 0 = empty load.
REQ-008 IN_DATA  in  DATA_WIDTH  SHALL be the stream byte.
REQ-009 IN_VALID  in  1  SHALL qualify IN_DATA.
REQ-010 IN_READY  out  1  SHALL signal the loader accepts a byte; transfer occurs when IN_VALID and IN_READY are high at a posedge.
REQ-011 MEM_A  out  ADDR_WIDTH  SHALL be the RAM address.
REQ-012 MEM_DIO  inout  DATA_WIDTH  SHALL be the RAM data bus; driven only while MEM_WR_N=0, else high-Z.
REQ-013 MEM_CS_N, MEM_OE_N, MEM_WR_N  out  1 each  SHALL be the RAM chip select, output enable and write enable, all active-low.
REQ-014 BUSY  out  1  SHALL be high in every state except IDLE.
REQ-015 DONE  out  1  SHALL pulse for exactly one cycle at load completion.
REQ-016 ERROR  out  1  SHALL flag verify mismatch; held until the next accepted START.
REQ-017 CHECKSUM  out  DATA_WIDTH  SHALL hold the sum mod 2^DATA_WIDTH of bytes written; held until the next accepted START.

Function
REQ-018 States SHALL be IDLE, LOAD, WRITE, RD_ADDR, RD_DATA, FINISH.
REQ-019 IDLE: START=1 at posedge -> capture BASE_ADDR/LEN, clear CHECKSUM, ERROR, verify sum; go LOAD if LEN!=0, else FINISH.
REQ-020 LOAD: IN_READY=1; on handshake register IN_DATA, add it to CHECKSUM, go WRITE; IN_VALID=0 -> remain in LOAD, no memory activity.
REQ-021 WRITE: exactly one cycle with MEM_CS_N=0, MEM_WR_N=0, MEM_OE_N=1, MEM_A=current address, MEM_DIO=registered byte; then address+1, remaining-1; go LOAD if remaining>0, else reload address from captured base and go RD_ADDR.
REQ-022 Write throughput SHALL be one byte per two cycles at most; IN_READY=0 in all states except LOAD.
REQ-023 RD_ADDR: MEM_CS_N=0, MEM_OE_N=0, MEM_WR_N=1, MEM_A=current address; go RD_DATA next cycle.
REQ-024 RD_DATA: hold RD_ADDR strobes and address; sample MEM_DIO at the ending posedge and add it to verify sum; address+1; go RD_ADDR if bytes remain, else FINISH.
REQ-025 Verify SHALL read exactly LEN bytes from the same addresses written.
REQ-026 FINISH: DONE=1 for one cycle; ERROR set if verify sum != CHECKSUM; go IDLE.
REQ-027 Address arithmetic SHALL wrap mod 2^ADDR_WIDTH in both phases.
REQ-028 Outside WRITE/RD_ADDR/RD_DATA, MEM_CS_N=MEM_OE_N=MEM_WR_N=1 and MEM_DIO high-Z.
REQ-029 START while BUSY SHALL be ignored; BASE_ADDR/LEN changes mid-load SHALL have no effect.
REQ-030 MEM_WR_N=0 and MEM_OE_N=0 SHALL never occur in the same cycle.

Reset
REQ-031 RESET_N=0 SHALL immediately force IDLE, BUSY=0, DONE=0, ERROR=0, CHECKSUM=0, IN_READY=0, MEM_A=0, all strobes high, MEM_DIO high-Z, regardless of state.
REQ-032 Reset mid-load SHALL abandon the load without DONE; RAM contents already written are undefined from the loader's perspective.

Verification
REQ-033 Reset asserted at arbitrary time -> all REQ-031 values within the same cycle, no strobe glitch low.
REQ-034 BASE_ADDR=0x0010, LEN=3, stream A5,5A,FF with IN_VALID held -> writes at 0x0010/0x0011/0x0012, then reads same addresses, CHECKSUM=0xFE, ERROR=0, one DONE pulse.
REQ-035 BASE_ADDR=0x7FFF, LEN=2, stream 11,22 -> writes to 0x7FFF then 0x0000, CHECKSUM=0x33, ERROR=0.
REQ-036 LEN=0 with START -> no strobe asserted, DONE high the cycle after START, CHECKSUM=0.
REQ-037 IN_VALID toggled with 3-cycle gaps plus START pulsed mid-load -> no extra writes, BUSY stays 1, second START ignored, final result as if uninterrupted.
REQ-038 RAM model corrupts byte at BASE_ADDR+1 before verify (LEN=4) -> ERROR=1 at DONE, held until next START.
